pattern_fetch_ctrl: RTL

//  Per-frame sequencer for the rectangle pattern ROM (38-bit entries: x0[37:28] y0[27:19] x1[18:9] y1[8:0]).
//  On each frame-start pulse it reads the ENTRIES rectangles of the selected pattern from the ROM.
//  It discards malformed entries and streams the valid ones to the rectangle renderer over a valid/ready handshake.
//  It sits between the VGA timing generator (frame_start) and the ROM/renderer pair.

---
 rtl/pattern_fetch_ctrl_if.sv | 34 +++
 rtl/pattern_fetch_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_fetch_ctrl_if.sv
// Control, ROM-read and rectangle-stream signals of the pattern fetch sequencer.
// master = sequencer side, slave = timing generator / ROM / renderer side.
interface pattern_fetch_ctrl_if #(
  parameter int ROM_AW = 8,
  parameter int PSW    = 3
);
  logic              frame_start;
  logic [PSW-1:0]    pat_sel;
  logic              p_oe;
  logic [ROM_AW-1:0] p_Addr;
  logic [37:0]       p_Data;
  logic              rect_valid;
  logic              rect_ready;
  logic [9:0]        rect_x0;
  logic [9:0]        rect_x1;
  logic [8:0]        rect_y0;
  logic [8:0]        rect_y1;
  logic [4:0]        rect_idx;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    input  frame_start, pat_sel, p_Data, rect_ready,
    output p_oe, p_Addr, rect_valid, rect_x0, rect_x1, rect_y0, rect_y1,
           rect_idx, busy, done, overrun
  );

  modport slave (
    output frame_start, pat_sel, p_Data, rect_ready,
    input  p_oe, p_Addr, rect_valid, rect_x0, rect_x1, rect_y0, rect_y1,
           rect_idx, busy, done, overrun
  );
endinterface

// File: rtl/pattern_fetch_ctrl.sv
// Per-frame rectangle list sequencer: ROM read -> validity check -> valid/ready stream.
// First rect_valid 4 cycles after frame_start; a stalled rect_ready holds the FSM in PRESENT.
module pattern_fetch_ctrl #(
  parameter int          ENTRIES = 30,
  parameter int          NPAT    = 8,
  parameter int          ROM_AW  = 8,
  parameter logic [37:0] TERM    = 38'h3F_FFFF_FFFF
) (
  input logic                  clk,
  input logic                  reset,
  pattern_fetch_ctrl_if.master bus
);

  localparam int                IDXW      = 5;
  localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(ENTRIES - 1);
  localparam logic [ROM_AW-1:0] ENTRIES_A = ROM_AW'(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ROM_AW-1:0] base_q;
  logic [IDXW-1:0]   idx_q;
  logic [37:0]       word_q;
  logic              p_oe_q;
  logic [ROM_AW-1:0] p_addr_q;
  logic              rect_valid_q;
  logic [9:0]        rect_x0_q;
  logic [9:0]        rect_x1_q;
  logic [8:0]        rect_y0_q;
  logic [8:0]        rect_y1_q;
  logic [IDXW-1:0]   rect_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic [ROM_AW-1:0] pat_ext;
  logic [ROM_AW-1:0] base_d;
  logic [IDXW-1:0]   idx_d;
  logic [ROM_AW-1:0] addr_d;
  logic [9:0]        w_x0;
  logic [8:0]        w_y0;
  logic [9:0]        w_x1;
  logic [8:0]        w_y1;
  logic              is_term;
  logic              is_bad;
  logic              is_last;

  // Out-of-range pattern indices fall back to pattern 0.
  always_comb begin
    pat_ext = '0;
    if (int'(bus.pat_sel) < NPAT) begin
      pat_ext = ROM_AW'(bus.pat_sel);
    end
    if (ENTRIES == 30) begin
      base_d = (pat_ext << 5) - (pat_ext << 1);
    end else begin
      base_d = pat_ext * ENTRIES_A;
    end
  end

  assign idx_d  = idx_q + IDXW'(1);
  assign addr_d = base_q + ROM_AW'(idx_d);

  assign w_x0    = word_q[37:28];
  assign w_y0    = word_q[27:19];
  assign w_x1    = word_q[18:9];
  assign w_y1    = word_q[8:0];
  assign is_term = (word_q == TERM);
  assign is_bad  = (w_x1 < w_x0) || (w_y1 < w_y0);
  assign is_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      p_oe_q       <= 1'b0;
      p_addr_q     <= '0;
      rect_valid_q <= 1'b0;
      rect_x0_q    <= '0;
      rect_x1_q    <= '0;
      rect_y0_q    <= '0;
      rect_y1_q    <= '0;
      rect_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      p_oe_q <= 1'b0;
      done_q <= 1'b0;

      if (bus.frame_start && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.frame_start) begin
            base_q   <= base_d;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            p_oe_q   <= 1'b1;
            p_addr_q <= base_d;
            state_q  <= S_READ;
          end
        end

        S_READ: begin
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          word_q  <= bus.p_Data;
          state_q <= S_CHECK;
        end

        S_CHECK: begin
          if (is_term) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (is_bad) begin
            if (is_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q    <= idx_d;
              p_oe_q   <= 1'b1;
              p_addr_q <= addr_d;
              state_q  <= S_READ;
            end
          end else begin
            rect_x0_q    <= w_x0;
            rect_y0_q    <= w_y0;
            rect_x1_q    <= w_x1;
            rect_y1_q    <= w_y1;
            rect_idx_q   <= idx_q;
            rect_valid_q <= 1'b1;
            state_q      <= S_PRESENT;
          end
        end

        // rect_valid is registered, so ready only ever acts on the next edge.
        S_PRESENT: begin
          if (bus.rect_ready) begin
            rect_valid_q <= 1'b0;
            if (is_last) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q    <= idx_d;
              p_oe_q   <= 1'b1;
              p_addr_q <= addr_d;
              state_q  <= S_READ;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.p_oe       = p_oe_q;
  assign bus.p_Addr     = p_addr_q;
  assign bus.rect_valid = rect_valid_q;
  assign bus.rect_x0    = rect_x0_q;
  assign bus.rect_x1    = rect_x1_q;
  assign bus.rect_y0    = rect_y0_q;
  assign bus.rect_y1    = rect_y1_q;
  assign bus.rect_idx   = rect_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;

endmodule
